// File: rtl/adc_frame_pack.sv
// ADC frame packer: registers channel A/B beats, frames them on channel A
// sop/eop, and queues {tuser, tlast, chb, cha} words into a FWFT FIFO.
module adc_frame_pack #(
  parameter int FRAME_LEN = 1024,
  parameter int FIFO_AW   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] adc_data_cha,
  input  logic [15:0] adc_data_chb,
  input  logic        adc_data_sop_cha,
  input  logic        adc_data_eop_cha,
  input  logic        adc_data_valid_cha,
  input  logic        adc_data_valid_chb,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic [15:0] frame_cnt,
  output logic        len_err,
  output logic        align_err,
  output logic        ovf_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [15:0] FLEN = 16'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE,
    IN_FRAME,
    DROP
  } state_t;

  // Input stage register
  logic        s_vld_q;
  logic        s_sop_q;
  logic        s_eop_q;
  logic [31:0] s_data_q;
  logic        align_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_vld_q  <= 1'b0;
      s_sop_q  <= 1'b0;
      s_eop_q  <= 1'b0;
      s_data_q <= '0;
      align_q  <= 1'b0;
    end else begin
      s_vld_q  <= adc_data_valid_cha;
      s_sop_q  <= adc_data_sop_cha;
      s_eop_q  <= adc_data_eop_cha;
      s_data_q <= {adc_data_chb, adc_data_cha};
      align_q  <= adc_data_valid_cha ^ adc_data_valid_chb;
    end
  end

  // FIFO storage and pointers
  logic [33:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   cnt_q;
  logic [FIFO_AW:0]   cnt_d;
  logic               full;
  logic               empty;
  logic               rd_en;
  logic               wr_en;
  logic               wr_ok;
  logic [33:0]        rd_word;

  // FSM signals
  state_t      state_q;
  state_t      state_d;
  logic [15:0] scnt_q;
  logic [15:0] scnt_d;
  logic [15:0] scnt_inc;
  logic [15:0] frame_cnt_q;
  logic        ovf_q;
  logic        wr_req;
  logic        wr_user;
  logic        wr_last;
  logic        len_bad;
  logic        frame_hit;
  logic        ovf_hit;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign rd_en = !empty && m_tready;
  // A read in the same cycle frees the slot the write needs
  assign wr_ok = !full || rd_en;
  assign wr_en = wr_req && wr_ok;

  assign scnt_inc = (scnt_q == 16'hFFFF) ? scnt_q : scnt_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    wr_req    = 1'b0;
    wr_user   = 1'b0;
    wr_last   = 1'b0;
    len_bad   = 1'b0;
    frame_hit = 1'b0;
    ovf_hit   = 1'b0;
    if (s_vld_q) begin
      if (s_sop_q) begin
        wr_req  = 1'b1;
        wr_user = 1'b1;
        wr_last = s_eop_q;
        scnt_d  = 16'd1;
        len_bad = (state_q == IN_FRAME);
        if (s_eop_q) begin
          state_d = IDLE;
          if (FLEN == 16'd1) frame_hit = 1'b1;
          else               len_bad   = 1'b1;
        end else begin
          state_d = IN_FRAME;
        end
      end else begin
        unique case (state_q)
          IN_FRAME: begin
            wr_req  = 1'b1;
            wr_last = s_eop_q;
            scnt_d  = scnt_inc;
            if (s_eop_q) begin
              state_d = IDLE;
              if (scnt_inc == FLEN) frame_hit = 1'b1;
              else                  len_bad   = 1'b1;
            end
          end
          DROP: begin
            if (s_eop_q) state_d = IDLE;
          end
          default: ;
        endcase
      end
      if (wr_req && !wr_ok) begin
        ovf_hit   = 1'b1;
        frame_hit = 1'b0;
        state_d   = DROP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      scnt_q      <= '0;
      frame_cnt_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      scnt_q      <= scnt_d;
      frame_cnt_q <= frame_cnt_q + {15'd0, frame_hit};
      ovf_q       <= ovf_q | ovf_hit;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {wr_user, wr_last, s_data_q};
  end

  // Outputs read zero while the FIFO is empty
  assign rd_word   = mem_q[rd_ptr_q];
  assign m_tvalid  = !empty;
  assign m_tdata   = empty ? '0 : rd_word[31:0];
  assign m_tuser   = !empty && rd_word[33];
  assign m_tlast   = !empty && rd_word[32];
  assign frame_cnt = frame_cnt_q;
  assign len_err   = len_bad;
  assign align_err = align_q;
  assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_adc_frame_pack.sv
// Bench for adc_frame_pack: table-driven frames, hand-written corner
// sequences, and a random stream checked against a frame-level model.
module tb_adc_frame_pack;
  localparam int FL = 8;
  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cha, chb;
  logic        sop, eop, va, vb;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast, m_tuser;
  logic [15:0] frame_cnt;
  logic        len_err, align_err, ovf_err;

  adc_frame_pack #(.FRAME_LEN(FL), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .adc_data_cha(cha), .adc_data_chb(chb),
    .adc_data_sop_cha(sop), .adc_data_eop_cha(eop),
    .adc_data_valid_cha(va), .adc_data_valid_chb(vb),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .frame_cnt(frame_cnt),
    .len_err(len_err), .align_err(align_err), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    bit          u;
    bit          l;
  } beat_t;

  typedef struct {
    int n;
    bit se_first;
    bit eop_last;
    int gap;
    int exp_beats;
    int exp_len;
    int exp_fr;
    int exp_al;
  } vec_t;

  beat_t got_q[$];
  int    got_cyc[$];
  int    cyc = 0;
  int    len_pulses = 0;
  int    al_pulses = 0;
  int    checks = 0;
  int    errors = 0;

  always @(negedge clk) begin
    cyc++;
    if (m_tvalid && m_tready) begin
      got_q.push_back('{m_tdata, m_tuser, m_tlast});
      got_cyc.push_back(cyc);
    end
    if (len_err) len_pulses++;
    if (align_err) al_pulses++;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit v, input bit v2, input bit s,
                       input bit e, input logic [15:0] a,
                       input logic [15:0] b);
    va = v; vb = v2; sop = s; eop = e; cha = a; chb = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    va = 0; vb = 0; sop = 0; eop = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    got_q.delete();
    got_cyc.delete();
    len_pulses = 0;
    al_pulses = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " tvalid"}, m_tvalid, 0);
    chk({tag, " tdata"}, m_tdata, 0);
    chk({tag, " tuser"}, m_tuser, 0);
    chk({tag, " tlast"}, m_tlast, 0);
    chk({tag, " frame_cnt"}, frame_cnt, 0);
    chk({tag, " len_err"}, len_err, 0);
    chk({tag, " align_err"}, align_err, 0);
    chk({tag, " ovf_err"}, ovf_err, 0);
  endtask

  task automatic good_frame(input string tag);
    logic [15:0] f0;
    f0 = frame_cnt;
    clr();
    for (int i = 0; i < FL; i++)
      drive(1, 1, i == 0, i == FL - 1, 16'(i + 1), 16'(16'h1000 + i + 1));
    idle(6);
    chk({tag, " beats"}, got_q.size(), FL);
    chk({tag, " frame_cnt"}, 16'(frame_cnt - f0), 1);
    chk({tag, " len_err"}, len_pulses, 0);
  endtask

  vec_t  vt[5];
  beat_t exp_q[$];

  initial begin
    logic [15:0] f0;
    logic [31:0] d0;
    int          bad, nu, nl, k;

    vt[0] = '{8, 0, 1, -1, 8, 0, 1, 0};
    vt[1] = '{5, 0, 1, -1, 5, 1, 0, 0};
    vt[2] = '{8, 0, 1, 3, 8, 0, 1, 1};
    vt[3] = '{4, 1, 0, -1, 1, 1, 0, 0};
    vt[4] = '{10, 0, 1, -1, 10, 1, 0, 0};

    rst = 1; va = 0; vb = 0; sop = 0; eop = 0;
    cha = 0; chb = 0; m_tready = 1;
    #1;
    chk_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    idle(2);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      f0 = frame_cnt;
      clr();
      for (int i = 0; i < vt[v].n; i++) begin
        drive(1, i != vt[v].gap, i == 0,
              vt[v].se_first ? (i == 0) : (vt[v].eop_last && i == vt[v].n - 1),
              16'(i + 1), 16'(16'h1000 + i + 1));
      end
      idle(6);
      chk($sformatf("v%0d beats", v), got_q.size(), vt[v].exp_beats);
      chk($sformatf("v%0d len_err", v), len_pulses, vt[v].exp_len);
      chk($sformatf("v%0d align_err", v), al_pulses, vt[v].exp_al);
      chk($sformatf("v%0d frames", v), 16'(frame_cnt - f0), vt[v].exp_fr);
      if (got_q.size() > 0) begin
        k = got_q.size();
        bad = 0; nu = 0; nl = 0;
        foreach (got_q[i]) begin
          if (got_q[i].d !== {16'(16'h1000 + i + 1), 16'(i + 1)}) bad++;
          nu += got_q[i].u;
          nl += got_q[i].l;
        end
        chk($sformatf("v%0d first", v), got_q[0].d, 32'h10010001);
        chk($sformatf("v%0d tuser0", v), got_q[0].u, 1);
        chk($sformatf("v%0d tlast", v), got_q[k-1].l, 1);
        chk($sformatf("v%0d data", v), bad, 0);
        chk($sformatf("v%0d nuser", v), nu, 1);
        chk($sformatf("v%0d nlast", v), nl, 1);
        chk($sformatf("v%0d rate", v), got_cyc[k-1] - got_cyc[0], k - 1);
      end
    end

    // Latency and hold under back-pressure
    clr();
    f0 = frame_cnt;
    m_tready = 0;
    drive(1, 1, 1, 0, 16'h00A1, 16'h00B1);
    chk("lat1 tvalid", m_tvalid, 0);
    idle(1);
    chk("lat2 tvalid", m_tvalid, 1);
    chk("lat2 tdata", m_tdata, 32'h00B100A1);
    chk("lat2 tuser", m_tuser, 1);
    d0 = m_tdata;
    idle(3);
    chk("hold tdata", m_tdata, d0);
    chk("hold tuser", m_tuser, 1);
    chk("hold tvalid", m_tvalid, 1);
    for (int i = 1; i < FL; i++)
      drive(1, 1, 0, i == FL - 1, 16'(16'h00A1 + i), 16'(16'h00B1 + i));
    idle(4);
    chk("bp frames", 16'(frame_cnt - f0), 1);
    chk("bp held", got_q.size(), 0);
    m_tready = 1;
    idle(12);
    chk("bp beats", got_q.size(), FL);
    if (got_q.size() == FL) chk("bp last", got_q[FL-1].l, 1);
    chk("bp ovf", ovf_err, 0);

    // Overflow: 20 beats into a stalled 16-deep FIFO
    clr();
    f0 = frame_cnt;
    m_tready = 0;
    for (int i = 0; i < 20; i++)
      drive(1, 1, i == 0, 0, 16'(16'h0100 + i), 16'(16'h0200 + i));
    drive(1, 1, 0, 0, 16'h0AAA, 16'h0BBB);
    drive(1, 1, 0, 1, 16'h0CCC, 16'h0DDD);
    idle(4);
    chk("ovf flag", ovf_err, 1);
    chk("ovf held", got_q.size(), 0);
    m_tready = 1;
    idle(24);
    chk("ovf beats", got_q.size(), 16);
    bad = 0; nu = 0; nl = 0;
    foreach (got_q[i]) begin
      if (got_q[i].d !== {16'(16'h0200 + i), 16'(16'h0100 + i)}) bad++;
      nu += got_q[i].u;
      nl += got_q[i].l;
    end
    chk("ovf data", bad, 0);
    chk("ovf nuser", nu, 1);
    chk("ovf nlast", nl, 0);
    chk("ovf frames", 16'(frame_cnt - f0), 0);
    chk("ovf len_err", len_pulses, 0);
    good_frame("post_ovf");
    chk("ovf sticky", ovf_err, 1);

    // Asynchronous reset in the middle of a frame
    clr();
    for (int i = 0; i < 3; i++)
      drive(1, 1, i == 0, 0, 16'(i + 1), 16'(16'h1000 + i + 1));
    va = 1; vb = 1; sop = 0; eop = 0; cha = 16'd4; chb = 16'h1004;
    #2;
    rst = 1;
    #1;
    chk_zero("async_rst");
    @(posedge clk); #1;
    rst = 0;
    clr();
    for (int i = 4; i < FL; i++)
      drive(1, 1, 0, i == FL - 1, 16'(i + 1), 16'(16'h1000 + i + 1));
    idle(5);
    chk("rst tail ignored", got_q.size(), 0);
    chk("rst tail len_err", len_pulses, 0);
    good_frame("post_rst");
    chk("post_rst count", frame_cnt, 1);

    // Random stream against a frame-level model
    begin
      bit   inf, rv, rvb, rs, re;
      int   mlen, exp_len, exp_al, exp_fr, err;
      logic [15:0] ra, rb;
      inf = 0; mlen = 0; exp_len = 0; exp_al = 0; exp_fr = 0;
      exp_q.delete();
      f0 = frame_cnt;
      clr();
      for (int c = 0; c < 600; c++) begin
        rv  = ($urandom % 10) < 8;
        rvb = ($urandom % 20 == 0) ? !rv : rv;
        rs  = ($urandom % 12) == 0;
        re  = (inf && mlen == FL - 1) ? ($urandom % 2 == 0)
                                     : ($urandom % 15 == 0);
        ra  = 16'($urandom);
        rb  = 16'($urandom);
        if (rv) begin
          err = 0;
          if (rs) begin
            if (inf) err = 1;
            exp_q.push_back('{{rb, ra}, 1'b1, re});
            mlen = 1;
            if (re) begin
              inf = 0;
              if (mlen == FL) exp_fr++; else err = 1;
            end else begin
              inf = 1;
            end
          end else if (inf) begin
            mlen++;
            exp_q.push_back('{{rb, ra}, 1'b0, re});
            if (re) begin
              inf = 0;
              if (mlen == FL) exp_fr++; else err = 1;
            end
          end
          exp_len += err;
        end
        if (rv != rvb) exp_al++;
        drive(rv, rvb, rs, re, ra, rb);
      end
      idle(8);
      chk("rnd beats", got_q.size(), exp_q.size());
      bad = 0;
      foreach (exp_q[i]) begin
        if (i < got_q.size()) begin
          if (got_q[i] != exp_q[i]) bad++;
        end
      end
      chk("rnd beat data", bad, 0);
      chk("rnd len_err", len_pulses, exp_len);
      chk("rnd align_err", al_pulses, exp_al);
      chk("rnd frames", 16'(frame_cnt - f0), 16'(exp_fr));
      chk("rnd ovf", ovf_err, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
